uart_cmd_responder: RTL

Host-facing command responder on the byte streams of `uart_core`. It parses 2- or 3-byte command frames arriving on the receive stream and executes them as single register-bus reads or writes. It returns exactly one response byte per completed frame on the transmit stream. It is the device-side counterpart to a host that drives the UART link, replacing hand-driven button/LED exchanges with addressable register access.

---
 rtl/uart_cmd_responder_if.sv | 34 +++
 rtl/uart_cmd_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder_if.sv
// ============================================================================
// Module   : uart_cmd_responder_if
// Purpose  : Byte-stream and register-bus signal bundle of uart_cmd_responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_cmd_responder_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       bus_wr;
   logic       bus_rd;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;
   logic [7:0] err_cnt;

   // Responder side
   modport slave (
      input  rx_valid, rx_data, tx_ready, bus_rdata,
      output tx_valid, tx_data, bus_wr, bus_rd, bus_addr, bus_wdata, err_cnt
   );

   // Host / UART / register-file side
   modport master (
      output rx_valid, rx_data, tx_ready, bus_rdata,
      input  tx_valid, tx_data, bus_wr, bus_rd, bus_addr, bus_wdata, err_cnt
   );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_responder.sv
// ============================================================================
// Module   : uart_cmd_responder
// Purpose  : Parses 'W'/'R' command frames from a UART byte stream into single
//            register-bus accesses and returns one response byte per frame.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_responder #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  wire                   clk,
   input  wire                   rst,
   uart_cmd_responder_if.slave   cmd_if
);

   localparam int                CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [7:0]        CMD_WR  = 8'h57;
   localparam logic [7:0]        CMD_RD  = 8'h52;
   localparam logic [7:0]        RSP_OK  = 8'h4B;
   localparam logic [7:0]        RSP_BAD = 8'h3F;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      DATA    = 3'd2,
      EXEC_WR = 3'd3,
      EXEC_RD = 3'd4,
      RD_WAIT = 3'd5,
      RESP    = 3'd6
   } state_t;

   state_t           state_q,     state_d;
   logic             cmd_wr_q,    cmd_wr_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             tx_valid_q,  tx_valid_d;
   logic [7:0]       tx_data_q,   tx_data_d;
   logic             bus_wr_q,    bus_wr_d;
   logic             bus_rd_q,    bus_rd_d;
   logic [7:0]       bus_addr_q,  bus_addr_d;
   logic [7:0]       bus_wdata_q, bus_wdata_d;
   logic [7:0]       err_cnt_q,   err_cnt_d;
   logic             err_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_wr_q    <= 1'b0;
         cnt_q       <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         bus_wr_q    <= 1'b0;
         bus_rd_q    <= 1'b0;
         bus_addr_q  <= 8'h00;
         bus_wdata_q <= 8'h00;
         err_cnt_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         cmd_wr_q    <= cmd_wr_d;
         cnt_q       <= cnt_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         bus_wr_q    <= bus_wr_d;
         bus_rd_q    <= bus_rd_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Strobes and tx_valid are decoded from the next state so every output
   // leaves a flop while still meeting the one-cycle-per-stage latencies.
   always_comb begin
      state_d     = state_q;
      cmd_wr_d    = cmd_wr_q;
      cnt_d       = cnt_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      bus_wr_d    = 1'b0;
      bus_rd_d    = 1'b0;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      err_inc     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cmd_if.rx_valid) begin
               if (cmd_if.rx_data == CMD_WR) begin
                  cmd_wr_d = 1'b1;
                  state_d  = ADDR;
               end else if (cmd_if.rx_data == CMD_RD) begin
                  cmd_wr_d = 1'b0;
                  state_d  = ADDR;
               end else begin
                  tx_data_d  = RSP_BAD;
                  tx_valid_d = 1'b1;
                  state_d    = RESP;
               end
            end
         end
         ADDR: begin
            if (cmd_if.rx_valid) begin
               bus_addr_d = cmd_if.rx_data;
               cnt_d      = '0;
               if (cmd_wr_q) begin
                  state_d = DATA;
               end else begin
                  state_d  = EXEC_RD;
                  bus_rd_d = 1'b1;
               end
            end else if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (cmd_if.rx_valid) begin
               bus_wdata_d = cmd_if.rx_data;
               cnt_d       = '0;
               bus_wr_d    = 1'b1;
               state_d     = EXEC_WR;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         EXEC_WR: begin
            err_inc    = cmd_if.rx_valid;
            tx_data_d  = RSP_OK;
            tx_valid_d = 1'b1;
            state_d    = RESP;
         end
         EXEC_RD: begin
            err_inc = cmd_if.rx_valid;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            err_inc    = cmd_if.rx_valid;
            tx_data_d  = cmd_if.bus_rdata;
            tx_valid_d = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            // A byte arriving in the hand-off cycle is still a drop.
            err_inc = cmd_if.rx_valid;
            if (cmd_if.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
         end
      endcase

      err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'h01 : err_cnt_q;
   end

   assign cmd_if.tx_valid  = tx_valid_q;
   assign cmd_if.tx_data   = tx_data_q;
   assign cmd_if.bus_wr    = bus_wr_q;
   assign cmd_if.bus_rd    = bus_rd_q;
   assign cmd_if.bus_addr  = bus_addr_q;
   assign cmd_if.bus_wdata = bus_wdata_q;
   assign cmd_if.err_cnt   = err_cnt_q;

endmodule

`default_nettype wire
